// File: rtl/ppe_sched.sv
// ppe_sched: round-robin scheduler merging NUM_REQ packet streams onto one registered PPE port.
// Define PPE_SCHED_WCHECK_EN to hold input packets until their address has seen WT_PKTS weights.
module ppe_sched #(
    parameter int  NUM_REQ = 4,
    parameter int  PKT_W   = 30,
    parameter int  WT_PKTS = 2,
    localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*PKT_W-1:0] req_pkt,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [PKT_W-1:0]         out_pkt,
    output logic [SRC_W-1:0]         out_src,
    input  logic                     out_ready,
    input  logic                     wt_clr,
    output logic [NUM_REQ-1:0]       blocked
);
    logic [PKT_W-1:0]   pkt_s [NUM_REQ];
    logic [NUM_REQ-1:0] blk_s;
    logic [NUM_REQ-1:0] elig_s;
    logic [NUM_REQ-1:0] grant_s;
    logic               grant_found_s;
    logic [SRC_W-1:0]   grant_idx_s;
    logic               cap_s;
    logic [PKT_W-1:0]   sel_pkt_s;

    logic               out_valid_q, out_valid_d;
    logic [PKT_W-1:0]   out_pkt_q, out_pkt_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] blocked_q, blocked_d;

    // Split the flat request bus into per-requester packets
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pkt_s[i] = req_pkt[i*PKT_W +: PKT_W];
        end
    end

`ifdef PPE_SCHED_WCHECK_EN
    localparam int CNT_W = $clog2(WT_PKTS + 1);

    logic [CNT_W-1:0] wcnt_q [16];
    logic [CNT_W-1:0] wcnt_d [16];
    logic [3:0]       sel_addr_s;
    logic             wt_cap_s;

    // Input packets wait until their address holds a full set of weights
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pkt_s[i][PKT_W-5] && (wcnt_q[pkt_s[i][PKT_W-1 -: 4]] < CNT_W'(WT_PKTS))) begin
                blk_s[i] = 1'b1;
            end else begin
                blk_s[i] = 1'b0;
            end
        end
    end

    // Weight counters: saturating count per address; a coincident clear keeps only the new weight
    always_comb begin
        sel_addr_s = sel_pkt_s[PKT_W-1 -: 4];
        wt_cap_s   = cap_s && !sel_pkt_s[PKT_W-5];
        for (int a = 0; a < 16; a++) begin
            if (wt_cap_s && (sel_addr_s == 4'(a))) begin
                if (wt_clr) begin
                    wcnt_d[a] = CNT_W'(1'b1);
                end else if (wcnt_q[a] < CNT_W'(WT_PKTS)) begin
                    wcnt_d[a] = wcnt_q[a] + CNT_W'(1'b1);
                end else begin
                    wcnt_d[a] = wcnt_q[a];
                end
            end else if (wt_clr) begin
                wcnt_d[a] = {CNT_W{1'b0}};
            end else begin
                wcnt_d[a] = wcnt_q[a];
            end
        end
    end

    // Weight counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < 16; a++) begin
                wcnt_q[a] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int a = 0; a < 16; a++) begin
                wcnt_q[a] <= wcnt_d[a];
            end
        end
    end
`else
    logic unused_wt_clr_s;

    assign blk_s           = {NUM_REQ{1'b0}};
    assign unused_wt_clr_s = wt_clr;
`endif

    // Round-robin search over eligible requesters, starting one past the last grant
    always_comb begin
        elig_s        = req_valid & ~blk_s;
        grant_found_s = |elig_s;
        grant_idx_s   = ptr_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (elig_s[SRC_W'((int'(ptr_q) + k) % NUM_REQ)]) begin
                grant_idx_s = SRC_W'((int'(ptr_q) + k) % NUM_REQ);
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
        cap_s     = grant_found_s && (!out_valid_q || out_ready);
        sel_pkt_s = pkt_s[grant_idx_s];
        grant_s   = {NUM_REQ{1'b0}};
        if (cap_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = {NUM_REQ{1'b0}};
        end
    end

    assign req_ready = grant_s & {NUM_REQ{rst_n}};

    // Output register, arbitration pointer and blocked flags next state
    always_comb begin
        out_valid_d = out_valid_q;
        out_pkt_d   = out_pkt_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        blocked_d   = req_valid & blk_s;
        if (cap_s) begin
            out_valid_d = 1'b1;
            out_pkt_d   = sel_pkt_s;
            out_src_d   = grant_idx_s;
            ptr_d       = grant_idx_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_pkt_q   <= {PKT_W{1'b0}};
            out_src_q   <= {SRC_W{1'b0}};
            ptr_q       <= SRC_W'(NUM_REQ - 1);
            blocked_q   <= {NUM_REQ{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_pkt_q   <= out_pkt_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
            blocked_q   <= blocked_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pkt   = out_pkt_q;
    assign out_src   = out_src_q;
    assign blocked   = blocked_q;

endmodule

// File: tb/tb_ppe_sched.sv
// Directed self-checking bench for ppe_sched; expectations adapt to PPE_SCHED_WCHECK_EN.
module tb_ppe_sched;
`ifdef PPE_SCHED_WCHECK_EN
    localparam bit WCHK = 1'b1;
`else
    localparam bit WCHK = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [119:0] req_pkt;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [29:0]  out_pkt;
    logic [1:0]   out_src;
    logic         out_ready;
    logic         wt_clr;
    logic [3:0]   blocked;

    int n_vec;
    int n_err;

    ppe_sched dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pkt(req_pkt),
        .req_ready(req_ready), .out_valid(out_valid), .out_pkt(out_pkt),
        .out_src(out_src), .out_ready(out_ready), .wt_clr(wt_clr), .blocked(blocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] mk(input logic [3:0] a, input logic op, input logic [24:0] d);
        return {a, op, d};
    endfunction

    task automatic set_pkt(input int i, input logic [29:0] v);
        req_pkt[i*30 +: 30] = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_valid = 4'b0000;
        wt_clr = 1'b0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        out_ready = 1'b1;
        wt_clr = 1'b0;
        for (int i = 0; i < 4; i++) set_pkt(i, mk(4'(i), 1'b0, 25'h1));
        req_valid = 4'b1111;
        #1;
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_pkt !== 30'h0) begin n_err++; $display("FAIL rst_out_pkt: got %h want 0", out_pkt); end
        n_vec++; if (out_src !== 2'd0) begin n_err++; $display("FAIL rst_out_src: got %0d want 0", out_src); end
        n_vec++; if (blocked !== 4'b0000) begin n_err++; $display("FAIL rst_blocked: got %b want 0000", blocked); end
        rst_n = 1'b1;
        req_valid = 4'b0000;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_weight_gate;
        do_reset();
        set_pkt(0, mk(4'd5, 1'b0, 25'h030201));
        req_valid = 4'b0001;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL w1_ready: got %b want 0001", req_ready); end
        tick();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL w1_valid: got %b want 1", out_valid); end
        n_vec++; if (out_pkt !== 30'h14030201) begin n_err++; $display("FAIL w1_pkt: got %h want 14030201", out_pkt); end
        n_vec++; if (out_src !== 2'd0) begin n_err++; $display("FAIL w1_src: got %0d want 0", out_src); end
        set_pkt(1, mk(4'd5, 1'b1, 25'h000111));
        req_valid = 4'b0010;
        #1;
        n_vec++; if (req_ready !== (WCHK ? 4'b0000 : 4'b0010)) begin n_err++; $display("FAIL in_early_ready: got %b want %b", req_ready, WCHK ? 4'b0000 : 4'b0010); end
        tick();
        n_vec++; if (blocked !== (WCHK ? 4'b0010 : 4'b0000)) begin n_err++; $display("FAIL in_early_blocked: got %b want %b", blocked, WCHK ? 4'b0010 : 4'b0000); end
        n_vec++; if (out_valid !== !WCHK) begin n_err++; $display("FAIL in_early_valid: got %b want %b", out_valid, !WCHK); end
        set_pkt(0, mk(4'd5, 1'b0, 25'h000222));
        req_valid = 4'b0011;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL w2_ready: got %b want 0001", req_ready); end
        tick();
        n_vec++; if (out_pkt !== 30'h14000222 || out_src !== 2'd0) begin n_err++; $display("FAIL w2_out: got %h/%0d want 14000222/0", out_pkt, out_src); end
        n_vec++; if (blocked !== (WCHK ? 4'b0010 : 4'b0000)) begin n_err++; $display("FAIL w2_blocked: got %b want %b", blocked, WCHK ? 4'b0010 : 4'b0000); end
        req_valid = 4'b0010;
        #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL in_pass_ready: got %b want 0010", req_ready); end
        tick();
        n_vec++; if (out_pkt !== 30'h16000111 || out_src !== 2'd1 || out_valid !== 1'b1) begin n_err++; $display("FAIL in_pass_out: got %h/%0d/%b want 16000111/1/1", out_pkt, out_src, out_valid); end
        n_vec++; if (blocked !== 4'b0000) begin n_err++; $display("FAIL in_pass_blocked: got %b want 0000", blocked); end
        req_valid = 4'b0000;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_round_robin;
        logic [29:0] exp_pkt;
        do_reset();
        for (int i = 0; i < 4; i++) set_pkt(i, mk(4'(i), 1'b0, 25'(32'h100 + i)));
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            exp_pkt = mk(4'(c % 4), 1'b0, 25'(32'h100 + c % 4));
            #1;
            n_vec++; if (req_ready !== 4'(1 << (c % 4))) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, 4'(1 << (c % 4))); end
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_src !== 2'(c % 4) || out_pkt !== exp_pkt) begin n_err++; $display("FAIL rr_out[%0d]: got %b/%0d/%h want 1/%0d/%h", c, out_valid, out_src, out_pkt, c % 4, exp_pkt); end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_back_pressure;
        do_reset();
        for (int i = 0; i < 4; i++) set_pkt(i, mk(4'(i + 8), 1'b0, 25'(32'h200 + i)));
        out_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_first_ready: got %b want 0001", req_ready); end
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready); end
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_pkt !== 30'h20000200 || out_src !== 2'd0) begin n_err++; $display("FAIL bp_hold[%0d]: got %b/%h/%0d want 1/20000200/0", c, out_valid, out_pkt, out_src); end
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready: got %b want 0010", req_ready); end
        tick();
        n_vec++; if (out_src !== 2'd1 || out_pkt !== 30'h24000201) begin n_err++; $display("FAIL bp_release_out: got %0d/%h want 1/24000201", out_src, out_pkt); end
        req_valid = 4'b0000;
    endtask

    task automatic test_wt_clr;
        do_reset();
        set_pkt(0, mk(4'd5, 1'b0, 25'h00000A));
        req_valid = 4'b0001;
        tick();
        tick();
        wt_clr = 1'b1;
        set_pkt(0, mk(4'd5, 1'b0, 25'h00000B));
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL clr_ready: got %b want 0001", req_ready); end
        tick();
        n_vec++; if (out_pkt !== 30'h1400000B) begin n_err++; $display("FAIL clr_out: got %h want 1400000B", out_pkt); end
        wt_clr = 1'b0;
        set_pkt(1, mk(4'd5, 1'b1, 25'h00000C));
        req_valid = 4'b0010;
        #1;
        n_vec++; if (req_ready !== (WCHK ? 4'b0000 : 4'b0010)) begin n_err++; $display("FAIL clr_in_ready: got %b want %b", req_ready, WCHK ? 4'b0000 : 4'b0010); end
        tick();
        n_vec++; if (blocked !== (WCHK ? 4'b0010 : 4'b0000)) begin n_err++; $display("FAIL clr_in_blocked: got %b want %b", blocked, WCHK ? 4'b0010 : 4'b0000); end
        set_pkt(0, mk(4'd5, 1'b0, 25'h00000D));
        req_valid = 4'b0011;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL refill_ready: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0010;
        #1;
        n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL refill_in_ready: got %b want 0010", req_ready); end
        tick();
        n_vec++; if (out_pkt !== 30'h1600000C || out_src !== 2'd1) begin n_err++; $display("FAIL refill_in_out: got %h/%0d want 1600000C/1", out_pkt, out_src); end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_xfer;
        do_reset();
        for (int i = 0; i < 4; i++) set_pkt(i, mk(4'(i), 1'b0, 25'(32'h300 + i)));
        out_ready = 1'b0;
        req_valid = 4'b0100;
        tick();
        n_vec++; if (out_valid !== 1'b1 || out_src !== 2'd2) begin n_err++; $display("FAIL mid_capture: got %b/%0d want 1/2", out_valid, out_src); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_pkt !== 30'h0) begin n_err++; $display("FAIL mid_rst_out: got %b/%h want 0/0", out_valid, out_pkt); end
        n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_restart_ready: got %b want 0001", req_ready); end
        tick();
        n_vec++; if (out_src !== 2'd0 || out_pkt !== 30'h00000300) begin n_err++; $display("FAIL mid_restart_out: got %0d/%h want 0/00000300", out_src, out_pkt); end
        req_valid = 4'b0000;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req_valid = 4'b0000;
        req_pkt = 120'h0;
        out_ready = 1'b1;
        wt_clr = 1'b0;
        test_reset();
        test_weight_gate();
        test_round_robin();
        test_back_pressure();
        test_wt_clr();
        test_reset_mid_xfer();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
